// File: rtl/eu_pkg.sv
// Shared definitions for the Execution Unit shift path: shifter micro-op
// encodings, request op encodings and the sequencer state type.
package eu_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_MOVB = 4'b1100;
  localparam logic [3:0] OP_SHR  = 4'b1101;
  localparam logic [3:0] OP_SHL  = 4'b1110;

  typedef enum logic [1:0] {
    REQ_MOV  = 2'b00,
    REQ_SHR  = 2'b01,
    REQ_SHL  = 2'b10,
    REQ_RSVD = 2'b11
  } req_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } seq_state_e;

endpackage

// File: rtl/eu_shift_sequencer_if.sv
// Request/response handshake between the control unit (master) and the
// shift sequencer (slave).
interface eu_shift_sequencer_if #(
  parameter int unsigned BUS_WIDTH = 16,
  parameter int unsigned CNT_WIDTH = 4
);
  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_op;
  logic [CNT_WIDTH-1:0] req_amount;
  logic [BUS_WIDTH-1:0] req_data;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [BUS_WIDTH-1:0] rsp_data;
  logic                 rsp_err;

  modport master (
    output req_valid, req_op, req_amount, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_amount, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/eu_shift_sequencer.sv
// Multi-cycle shift controller: loads the operand through the shifter with
// MOVB, then issues one single-bit SHR/SHL per cycle, feeding each result
// back into B, and returns the final value on the response channel.
module eu_shift_sequencer
  import eu_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 16,
  parameter int unsigned CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  eu_shift_sequencer_if.slave  bus,
  output logic [3:0]           eu_op_select,
  output logic [BUS_WIDTH-1:0] eu_B,
  input  logic [BUS_WIDTH-1:0] eu_data_out
);

  seq_state_e           state_q, state_d;
  req_op_e              op_q, op_d;
  logic [BUS_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] amount_q, amount_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 err_q, err_d;
  logic                 req_ready_q, req_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [3:0]           op_sel_q, op_sel_d;

  // Next-state, datapath and registered-output decode.
  // Outputs are decoded from the next state so they are flops aligned with
  // the state they describe, keeping req_*/rsp_ready off any output path.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    amount_d = amount_q;
    count_d  = count_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          op_d     = req_op_e'(bus.req_op);
          amount_d = bus.req_amount;
          acc_d    = bus.req_data;
          if (req_op_e'(bus.req_op) == REQ_RSVD) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        acc_d   = eu_data_out;
        count_d = amount_q;
        if (amount_q == '0 || op_q == REQ_MOV) state_d = ST_DONE;
        else                                   state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        acc_d   = eu_data_out;
        count_d = count_q - CNT_WIDTH'(1);
        if (count_q == CNT_WIDTH'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.rsp_ready) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_DONE);
    case (state_d)
      ST_LOAD:  op_sel_d = OP_MOVB;
      ST_SHIFT: op_sel_d = (op_d == REQ_SHR) ? OP_SHR : OP_SHL;
      default:  op_sel_d = OP_NOP;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= REQ_MOV;
      acc_q       <= '0;
      amount_q    <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      op_sel_q    <= OP_NOP;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      amount_q    <= amount_d;
      count_q     <= count_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      op_sel_q    <= op_sel_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = acc_q;
  assign bus.rsp_err   = err_q;
  assign eu_op_select  = op_sel_q;
  assign eu_B          = acc_q;

endmodule

// File: tb/tb_eu_shift_sequencer.sv
// Bench for eu_shift_sequencer with a behavioural eu_shifter beside it.
module tb_eu_shift_sequencer;
  import eu_pkg::*;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  amt;
    logic [15:0] data;
    logic [15:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  eu_op_select;
  logic [15:0] eu_B;
  logic [15:0] eu_data_out;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  logic [3:0] trace [8];
  int   trace_n;
  vec_t vecs [10];

  eu_shift_sequencer_if #(.BUS_WIDTH(16), .CNT_WIDTH(4)) bus_if ();

  eu_shift_sequencer #(.BUS_WIDTH(16), .CNT_WIDTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus_if),
    .eu_op_select (eu_op_select),
    .eu_B         (eu_B),
    .eu_data_out  (eu_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural eu_shifter
  always_comb begin
    case (eu_op_select)
      OP_MOVB: eu_data_out = eu_B;
      OP_SHR:  eu_data_out = eu_B >> 1;
      OP_SHL:  eu_data_out = eu_B << 1;
      default: eu_data_out = '0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_data(input logic [1:0] op, input logic [3:0] amt,
                                             input logic [15:0] d);
    case (op)
      2'b01:   return d >> amt;
      2'b10:   return d << amt;
      default: return d;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [3:0] amt);
    if (op == 2'b11) return 1;
    if (op == 2'b00 || amt == 4'd0) return 2;
    return 2 + int'(amt);
  endfunction

  // Scoreboard: compare each response at its handshake
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst && bus_if.rsp_valid && bus_if.rsp_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: actual=%0h required=none", bus_if.rsp_data);
      end else begin
        e = sb_q.pop_front();
        check("rsp_data", 32'(bus_if.rsp_data), 32'(e.data));
        check("rsp_err", 32'(bus_if.rsp_err), 32'(e.err));
      end
    end
  end

  task automatic finish_rsp();
    bus_if.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.rsp_ready = 1'b0;
    check("req_ready_after_rsp", 32'(bus_if.req_ready), 32'd1);
    check("rsp_valid_after_rsp", 32'(bus_if.rsp_valid), 32'd0);
  endtask

  task automatic do_req(input logic [1:0] op, input logic [3:0] amt, input logic [15:0] data,
                        input logic [15:0] exp_data, input logic exp_err, input int exp_lat,
                        input bit hold);
    int waits;
    int edges;
    @(negedge clk);
    bus_if.req_valid  = 1'b1;
    bus_if.req_op     = op;
    bus_if.req_amount = amt;
    bus_if.req_data   = data;
    waits = 0;
    while (!bus_if.req_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!bus_if.req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: actual=0 required=1");
      bus_if.req_valid = 1'b0;
      return;
    end
    sb_q.push_back('{data: exp_data, err: exp_err});
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    bus_if.req_valid  = 1'b0;
    bus_if.req_op     = 2'($urandom);
    bus_if.req_amount = 4'($urandom);
    bus_if.req_data   = 16'($urandom);
    trace_n = 0;
    while (!bus_if.rsp_valid && edges < 40) begin
      if (trace_n < 8) begin
        trace[trace_n] = eu_op_select;
        trace_n++;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (trace_n < 8) begin
      trace[trace_n] = eu_op_select;
      trace_n++;
    end
    check("latency", 32'(edges), 32'(exp_lat));
    if (!hold && bus_if.rsp_valid) finish_rsp();
  endtask

  initial begin
    rst = 1'b1;
    bus_if.req_valid  = 1'b0;
    bus_if.req_op     = '0;
    bus_if.req_amount = '0;
    bus_if.req_data   = '0;
    bus_if.rsp_ready  = 1'b0;

    vecs[0] = '{2'b01, 4'd1,  16'h1001, 16'h0800, 1'b0, 3};
    vecs[1] = '{2'b10, 4'd4,  16'h0001, 16'h0010, 1'b0, 6};
    vecs[2] = '{2'b10, 4'd15, 16'hcafe, 16'h0000, 1'b0, 17};
    vecs[3] = '{2'b00, 4'd5,  16'hface, 16'hface, 1'b0, 2};
    vecs[4] = '{2'b01, 4'd0,  16'hcafe, 16'hcafe, 1'b0, 2};
    vecs[5] = '{2'b11, 4'd7,  16'h1234, 16'h1234, 1'b1, 1};
    vecs[6] = '{2'b01, 4'd4,  16'hffff, 16'h0fff, 1'b0, 6};
    vecs[7] = '{2'b10, 4'd8,  16'h00ab, 16'hab00, 1'b0, 10};
    vecs[8] = '{2'b01, 4'd15, 16'h8000, 16'h0001, 1'b0, 17};
    vecs[9] = '{2'b10, 4'd1,  16'h8001, 16'h0002, 1'b0, 3};

    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(bus_if.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check("rst_op_select", 32'(eu_op_select), 32'(OP_NOP));
    check("rst_eu_B", 32'(eu_B), 32'd0);
    check("rst_rsp_data", 32'(bus_if.rsp_data), 32'd0);
    check("rst_rsp_err", 32'(bus_if.rsp_err), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      do_req(vecs[i].op, vecs[i].amt, vecs[i].data, vecs[i].exp_data,
             vecs[i].exp_err, vecs[i].exp_lat, 1'b0);

    // Micro-op trace of a one-bit SHR
    do_req(2'b01, 4'd1, 16'h1001, 16'h0800, 1'b0, 3, 1'b0);
    check("trace_load", 32'(trace[0]), 32'(OP_MOVB));
    check("trace_shift", 32'(trace[1]), 32'(OP_SHR));
    check("trace_done", 32'(trace[2]), 32'(OP_NOP));

    // Reserved op issues no shifter micro-op
    do_req(2'b11, 4'd3, 16'h1234, 16'h1234, 1'b1, 1, 1'b0);
    check("rsvd_trace_n", 32'(trace_n), 32'd1);
    check("rsvd_op_select", 32'(trace[0]), 32'(OP_NOP));

    // Backpressure: hold DONE for 5 cycles with a competing request present
    do_req(2'b01, 4'd3, 16'h00f0, 16'h001e, 1'b0, 5, 1'b1);
    bus_if.req_valid  = 1'b1;
    bus_if.req_op     = 2'b10;
    bus_if.req_amount = 4'd2;
    bus_if.req_data   = 16'h5555;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
      check("bp_rsp_data", 32'(bus_if.rsp_data), 32'h001e);
      check("bp_rsp_err", 32'(bus_if.rsp_err), 32'd0);
      check("bp_req_ready", 32'(bus_if.req_ready), 32'd0);
      check("bp_op_select", 32'(eu_op_select), 32'(OP_NOP));
    end
    bus_if.req_valid = 1'b0;
    finish_rsp();
    do_req(2'b10, 4'd2, 16'h0003, 16'h000c, 1'b0, 4, 1'b0);

    // Random requests against the reference model
    for (int r = 0; r < 12; r++) begin
      logic [1:0]  op;
      logic [3:0]  amt;
      logic [15:0] d;
      op  = 2'($urandom_range(0, 3));
      amt = 4'($urandom_range(0, 15));
      d   = 16'($urandom);
      do_req(op, amt, d, model_data(op, amt, d), op == 2'b11, model_lat(op, amt), 1'b0);
    end

    // Reset mid-SHIFT discards the operation
    @(negedge clk);
    bus_if.req_valid  = 1'b1;
    bus_if.req_op     = 2'b10;
    bus_if.req_amount = 4'd15;
    bus_if.req_data   = 16'hcafe;
    check("midrst_accept_ready", 32'(bus_if.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_in_shift", 32'(eu_op_select), 32'(OP_SHL));
    rst = 1'b1;
    #1;
    check("midrst_req_ready", 32'(bus_if.req_ready), 32'd1);
    check("midrst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check("midrst_op_select", 32'(eu_op_select), 32'(OP_NOP));
    check("midrst_rsp_data", 32'(bus_if.rsp_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus_if.rsp_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_no_rsp", 32'(bus_if.rsp_valid), 32'd0);
    bus_if.rsp_ready = 1'b0;

    do_req(2'b01, 4'd2, 16'h0100, 16'h0040, 1'b0, 4, 1'b0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
